// File: rtl/dmem_access_scheduler.sv
// Arbitrates the single-ported data memory between the load path and the store buffer.
// Optional misaligned-access trapping is compiled in with DMEM_MISALIGN_CHECK_EN.
module dmem_access_scheduler #(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned TAG_W      = 6,
   parameter int unsigned LOAD_LAT   = 2,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              ld_valid_i,
   output logic              ld_ready_o,
   input  logic [ADDR_W-1:0] ld_addr_i,
   input  logic [2:0]        ld_funct3_i,
   input  logic [TAG_W-1:0]  ld_tag_i,
   input  logic              st_valid_i,
   output logic              st_ready_o,
   input  logic [ADDR_W-1:0] st_addr_i,
   input  logic [2:0]        st_funct3_i,
   input  logic [31:0]       st_data_i,
   input  logic              flush_i,
   output logic              mem_write_o,
   output logic [2:0]        mem_funct3_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   input  logic [31:0]       mem_rdata_i,
   output logic              load_done_o,
   output logic [TAG_W-1:0]  load_tag_o,
   output logic [31:0]       load_data_o,
   output logic              misalign_err_o
);

   localparam int unsigned LatW    = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
   localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);
   localparam logic [LatW-1:0]    LatLast   = LatW'(LOAD_LAT - 1);
   localparam logic [StarveW-1:0] StarveTop = StarveW'(STARVE_MAX);

   typedef enum logic [1:0] {StIdle, StLoadWait, StStore} state_e;

   state_e              state_q;
   logic [LatW-1:0]     lat_q;
   logic [StarveW-1:0]  starve_q;
   logic                mem_write_q;
   logic [2:0]          mem_funct3_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [31:0]         mem_wdata_q;
   logic [TAG_W-1:0]    tag_q;
   logic                load_done_q;
   logic [TAG_W-1:0]    load_tag_q;
   logic [31:0]         load_data_q;

   logic st_grant;
   logic ld_grant;
   logic ld_mis;
   logic st_mis;

   // A store wins when it has starved long enough, when no load competes, or when loads are
   // blocked by flush; otherwise loads have priority.
   always_comb begin
      st_grant = 1'b0;
      ld_grant = 1'b0;
      if (state_q == StIdle) begin
         st_grant = st_valid_i && ((starve_q == StarveTop) || !ld_valid_i || flush_i);
         ld_grant = ld_valid_i && !flush_i && !st_grant;
      end
   end

`ifdef DMEM_MISALIGN_CHECK_EN
   logic misalign_q;

   function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
      logic mis;
      mis = 1'b0;
      case (funct3[1:0])
         2'b01:   mis = addr_lo[0];
         2'b10:   mis = |addr_lo;
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

   always_comb begin
      ld_mis = is_misaligned(ld_funct3_i, ld_addr_i[1:0]);
      st_mis = is_misaligned(st_funct3_i, st_addr_i[1:0]);
   end

   assign misalign_err_o = misalign_q;
`else
   assign ld_mis         = 1'b0;
   assign st_mis         = 1'b0;
   assign misalign_err_o = 1'b0;
`endif

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q      <= StIdle;
         lat_q        <= '0;
         starve_q     <= '0;
         mem_write_q  <= 1'b0;
         mem_funct3_q <= '0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         tag_q        <= '0;
         load_done_q  <= 1'b0;
         load_tag_q   <= '0;
         load_data_q  <= '0;
`ifdef DMEM_MISALIGN_CHECK_EN
         misalign_q   <= 1'b0;
`endif
      end else begin
         load_done_q <= 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
         misalign_q  <= 1'b0;
`endif

         if (st_grant) begin
            starve_q <= '0;
         end else if (ld_grant && st_valid_i && (starve_q != StarveTop)) begin
            starve_q <= starve_q + 1'b1;
         end

         unique case (state_q)
            StIdle: begin
               if (st_grant) begin
                  if (st_mis) begin
`ifdef DMEM_MISALIGN_CHECK_EN
                     misalign_q <= 1'b1;
`endif
                  end else begin
                     mem_addr_q   <= st_addr_i;
                     mem_funct3_q <= st_funct3_i;
                     mem_wdata_q  <= st_data_i;
                     mem_write_q  <= 1'b1;
                     state_q      <= StStore;
                  end
               end else if (ld_grant) begin
                  if (ld_mis) begin
`ifdef DMEM_MISALIGN_CHECK_EN
                     misalign_q <= 1'b1;
`endif
                  end else begin
                     mem_addr_q   <= ld_addr_i;
                     mem_funct3_q <= ld_funct3_i;
                     tag_q        <= ld_tag_i;
                     lat_q        <= '0;
                     state_q      <= StLoadWait;
                  end
               end
            end
            StLoadWait: begin
               // A flush abandons the read; the captured result of the previous load stays put.
               if (flush_i) begin
                  state_q <= StIdle;
               end else if (lat_q == LatLast) begin
                  load_data_q <= mem_rdata_i;
                  load_tag_q  <= tag_q;
                  load_done_q <= 1'b1;
                  state_q     <= StIdle;
               end else begin
                  lat_q <= lat_q + 1'b1;
               end
            end
            StStore: begin
               mem_write_q <= 1'b0;
               state_q     <= StIdle;
            end
            default: begin
               mem_write_q <= 1'b0;
               state_q     <= StIdle;
            end
         endcase
      end
   end

   assign ld_ready_o   = ld_grant;
   assign st_ready_o   = st_grant;
   assign mem_write_o  = mem_write_q;
   assign mem_funct3_o = mem_funct3_q;
   assign mem_addr_o   = mem_addr_q;
   assign mem_wdata_o  = mem_wdata_q;
   assign load_done_o  = load_done_q;
   assign load_tag_o   = load_tag_q;
   assign load_data_o  = load_data_q;

endmodule

// File: doc/dmem_access_scheduler.md
Name: dmem_access_scheduler

Overview:
- Sequences all accesses to the single-ported data memory and shares that memory between two requesters: the load path (EX/MEM loads) and the store buffer.
- Grants one access at a time, with load priority and store anti-starvation.
- Holds the memory address, funct3 and write data stable for the whole access.
- Returns load data with a tag and a one-cycle load_done pulse.

Parameters:
- ADDR_W, 32, width of the memory address passed to the data memory.
- TAG_W, 6, width of the load tag (ROB/destination tag).
- LOAD_LAT, 2, cycles the memory read path needs before data is valid. Minimum legal value 1.
- STARVE_MAX, 4, number of consecutive cycles a pending store may lose to loads before it is forced through.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- ld_valid  in  1  load request valid.
- ld_ready  out  1  load request accepted this cycle when ld_valid is also high.
- ld_addr  in  ADDR_W  load address.
- ld_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- ld_tag  in  TAG_W  load tag.
- st_valid  in  1  store request valid.
- st_ready  out  1  store request accepted this cycle when st_valid is also high.
- st_addr  in  ADDR_W  store address.
- st_funct3  in  3  store type: 000 SB, 001 SH, 010 SW.
- st_data  in  32  store data.
- flush  in  1  kill the in-flight load and block load acceptance.
- mem_write  out  1  write strobe to the data memory.
- mem_funct3  out  3  funct3 to the data memory.
- mem_addr  out  ADDR_W  address to the data memory.
- mem_wdata  out  32  write data to the data memory.
- mem_rdata  in  32  formatted load data from the data memory.
- load_done  out  1  one-cycle pulse: load result valid.
- load_tag  out  TAG_W  tag of the completed load.
- load_data  out  32  captured load result.
- misalign_err  out  1  misalignment pulse (see Optional Feature).

Behaviour:
- Reset values: every output and register is 0; state is IDLE; starvation counter is 0.
- States: IDLE, LOAD_WAIT, STORE.
- ld_ready and st_ready are high only in IDLE, and at most one of them is high in any cycle.
- Grant in IDLE:
  - If st_valid and (starve_cnt == STARVE_MAX or !ld_valid or flush), then st_ready = 1.
  - Otherwise ld_ready = ld_valid && !flush.
- Requesters must hold valid and payload stable until accepted. The ready signals are combinational from the valid inputs and internal state.
- starve_cnt:
  - Increments, saturating at STARVE_MAX, on each IDLE cycle where st_valid is high and the load is granted.
  - Clears to 0 when a store is accepted.
  - Holds in all other cycles.
- Load accepted at cycle T:
  - Registers addr, funct3 and tag; state goes to LOAD_WAIT.
  - mem_addr and mem_funct3 are driven from T+1 through T+LOAD_LAT.
  - At the end of cycle T+LOAD_LAT, mem_rdata is captured into load_data and load_tag is updated.
  - load_done = 1 in cycle T+LOAD_LAT+1 only; state returns to IDLE in that same cycle, so a new request can be accepted in T+LOAD_LAT+1.
- Store accepted at cycle T:
  - In cycle T+1, state is STORE with mem_write = 1 and mem_addr, mem_funct3 and mem_wdata taken from the registered request.
  - State returns to IDLE at the end of T+1; the next acceptance is possible at T+2.
- mem_write is 0 in every cycle except STORE.
- mem_addr, mem_funct3 and mem_wdata hold their last values when idle.
- flush:
  - In LOAD_WAIT: return to IDLE on the next edge with no load_done for that load.
  - In IDLE: blocks load acceptance only.
  - A store in the STORE state always completes.
- load_data and load_tag hold between completions; only load_done marks validity.
- Asynchronous reset mid-access: the access is abandoned, mem_write drops immediately, and no load_done is produced.

Optional Feature:
- Macro: DMEM_MISALIGN_CHECK_EN.
- Defined:
  - Misalignment is checked at acceptance:
    - LH, LHU and SH with addr[0] == 1 are misaligned.
    - LW and SW with addr[1:0] != 0 are misaligned.
  - A misaligned request is accepted (ready handshake completes) but issues no memory access.
  - misalign_err pulses for one cycle at T+1.
  - A misaligned load produces no load_done.
  - State stays IDLE.
- Undefined: no check is performed and misalign_err is tied to 0.

Test Plan:
- Reset, then an LW with ld_addr = 0x10, tag = 5, LOAD_LAT = 2, and mem_rdata = 0x13 at T+2 -> load_done in T+3 only, load_tag = 5, load_data = 0x13.
- Store-only SW with st_addr = 0x20 and st_data = 0xDEADBEEF accepted at T -> mem_write = 1 only in T+1 with mem_addr = 0x20 and mem_wdata = 0xDEADBEEF; st_ready = 0 in T+1.
- Back-to-back loads with st_valid held high -> after 4 consecutive lost grants (STARVE_MAX = 4), the store wins the next IDLE cycle and starve_cnt returns to 0.
- flush asserted at T+1 of a load with tag 7 -> no load_done for tag 7; ld_ready is 0 while flush is high; a subsequent load completes normally.
- reset asserted during STORE -> mem_write falls asynchronously, all outputs read 0, and state is IDLE afterwards.
- With DMEM_MISALIGN_CHECK_EN defined, SW to 0x22 -> misalign_err = 1 for one cycle and mem_write stays 0. Without the macro -> the write to 0x22 occurs and misalign_err stays 0.
